// File: rtl/cfpu_pipe.sv
// cfpu_pipe: pipelined complex floating-point ADD/SUB/MULT/MAC unit with
// N_CH independent complex accumulators.
// cfpu_pkg holds the shared float/complex types and the FPU ADD and MULT
// primitives: truncating, denormals flushed to zero, overflow saturates to inf.

package cfpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mantis;
    } floatType;

    typedef struct packed {
        floatType r;
        floatType i;
    } complex;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_MULT = 2'd2,
        OP_MAC  = 2'd3
    } op_e;

    localparam floatType F_ZERO = '0;
    localparam complex   C_ZERO = '0;

    function automatic floatType fp_neg(input floatType a);
        floatType n;
        n      = a;
        n.sign = ~a.sign;
        return n;
    endfunction

    // FPU ADD primitive
    function automatic floatType fp_add(input floatType a, input floatType b);
        floatType          x, y, res;
        logic [26:0]       mx, my;
        logic [27:0]       s;
        logic [7:0]        d;
        logic [4:0]        msb;
        logic signed [9:0] e;
        res = F_ZERO;
        // x always carries the larger magnitude, so d is never negative
        if ({a.exp, a.mantis} >= {b.exp, b.mantis}) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        if (x.exp == 8'd0) return F_ZERO;
        if (y.exp == 8'd0) return x;
        d  = x.exp - y.exp;
        mx = {1'b1, x.mantis, 3'b000};
        my = {1'b1, y.mantis, 3'b000};
        my = (d > 8'd26) ? 27'd0 : (my >> d);
        e  = $signed({2'b00, x.exp});
        if (x.sign == y.sign) begin
            s = {1'b0, mx} + {1'b0, my};
            if (s[27]) begin
                s = s >> 1;
                e = e + 10'sd1;
            end
        end else begin
            s = {1'b0, mx} - {1'b0, my};
            if (s == 28'd0) return F_ZERO;
            msb = 5'd0;
            for (int k = 0; k < 27; k++) begin
                if (s[k]) msb = 5'(k);
            end
            s = s << (5'd26 - msb);
            e = e - $signed({5'd0, 5'd26 - msb});
        end
        res.sign = x.sign;
        if (e <= 10'sd0) return F_ZERO;
        if (e >= 10'sd255) begin
            res.exp = 8'hff;
            return res;
        end
        res.exp    = e[7:0];
        res.mantis = s[25:3];
        return res;
    endfunction

    // FPU MULT primitive
    function automatic floatType fp_mul(input floatType a, input floatType b);
        floatType          res;
        logic [47:0]       m;
        logic signed [9:0] e;
        res = F_ZERO;
        if (a.exp == 8'd0 || b.exp == 8'd0) return F_ZERO;
        m = {24'd0, 1'b1, a.mantis} * {24'd0, 1'b1, b.mantis};
        e = $signed({2'b00, a.exp}) + $signed({2'b00, b.exp}) - 10'sd127;
        if (m[47]) begin
            e          = e + 10'sd1;
            res.mantis = m[46:24];
        end else begin
            res.mantis = m[45:23];
        end
        if (e <= 10'sd0) return F_ZERO;
        res.sign = a.sign ^ b.sign;
        if (e >= 10'sd255) begin
            res.exp    = 8'hff;
            res.mantis = '0;
            return res;
        end
        res.exp = e[7:0];
        return res;
    endfunction

    function automatic complex c_add(input complex a, input complex b);
        complex s;
        s.r = fp_add(a.r, b.r);
        s.i = fp_add(a.i, b.i);
        return s;
    endfunction

    function automatic complex c_neg(input complex a);
        complex n;
        n.r = fp_neg(a.r);
        n.i = fp_neg(a.i);
        return n;
    endfunction

    // (a.r*b.r - a.i*b.i) + j(a.i*b.r + a.r*b.i); subtraction by sign flip
    function automatic complex c_mul(input complex a, input complex b);
        complex p;
        p.r = fp_add(fp_mul(a.r, b.r), fp_neg(fp_mul(a.i, b.i)));
        p.i = fp_add(fp_mul(a.i, b.r), fp_mul(a.r, b.i));
        return p;
    endfunction

endpackage

module cfpu_pipe
    import cfpu_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int PIPE_MID = 1,
    parameter int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [1:0]      in_op,
    input  logic [CH_W-1:0] in_ch,
    input  logic            in_clr,
    input  complex          A,
    input  complex          B,
    output logic            out_valid,
    output logic [CH_W-1:0] out_ch,
    output complex          result
);

    typedef struct packed {
        logic            valid;
        op_e             op;
        logic [CH_W-1:0] ch;
        logic            clr;
    } ctrl_t;

    ctrl_t  s0_ctl;
    complex s0_a, s0_b, s0_val;
    ctrl_t  f_ctl;
    complex f_val;

    logic   ch_ok, is_mac;
    complex acc [N_CH];
    complex acc_base, acc_next, res_next;

    // S0 control: valid bit and tags, cleared by reset so in-flight samples die
    always_ff @(posedge clk) begin
        if (rst) s0_ctl <= '0;
        else     s0_ctl <= '{valid: in_valid, op: op_e'(in_op), ch: in_ch, clr: in_clr};
    end

    // S0 operands
    // NOTE: datapath registers are left unreset; the stage valid bit qualifies them.
    always_ff @(posedge clk) begin
        s0_a <= A;
        s0_b <= B;
    end

    // Product / pre-sum from the S0 operands
    always_comb begin
        s0_val = c_add(s0_a, s0_b);
        case (s0_ctl.op)
            OP_SUB:          s0_val = c_add(s0_a, c_neg(s0_b));
            OP_MULT, OP_MAC: s0_val = c_mul(s0_a, s0_b);
            default:         ;
        endcase
    end

    generate
        if (PIPE_MID != 0) begin : g_mid
            ctrl_t  s1_ctl;
            complex s1_val;

            // S1: register stage value and control between product and sum
            always_ff @(posedge clk) begin
                if (rst) s1_ctl <= '0;
                else     s1_ctl <= s0_ctl;
                s1_val <= s0_val;
            end

            assign f_ctl = s1_ctl;
            assign f_val = s1_val;
        end else begin : g_nomid
            assign f_ctl = s0_ctl;
            assign f_val = s0_val;
        end
    endgenerate

    assign ch_ok = (32'(f_ctl.ch) < 32'(N_CH));

    // Final stage: accumulator read, clear-before-add, and result select
    always_comb begin
        acc_base = C_ZERO;
        if (ch_ok && !f_ctl.clr) acc_base = acc[f_ctl.ch];
        acc_next = c_add(acc_base, f_val);
        is_mac   = ch_ok && (f_ctl.op == OP_MAC);
        res_next = is_mac ? acc_next : f_val;
    end

    // Accumulator write-back in the same cycle as the read, so MAC chains need no stall
    // NOTE: accumulators must start at zero after reset, so each is a reset flop, not a RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) acc[k] <= C_ZERO;
        end else if (f_ctl.valid && ch_ok) begin
            if (f_ctl.op == OP_MAC) acc[f_ctl.ch] <= acc_next;
            else if (f_ctl.clr)     acc[f_ctl.ch] <= C_ZERO;
        end
    end

    // Output register: result and tag hold across bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            result    <= C_ZERO;
        end else begin
            out_valid <= f_ctl.valid;
            if (f_ctl.valid) begin
                out_ch <= f_ctl.ch;
                result <= res_next;
            end
        end
    end

endmodule
